// File: rtl/poly_mod3_seq.sv
// poly_mod3_seq: walks a coefficient RAM and writes each coefficient reduced mod 3 to a result RAM
module poly_mod3_seq #(
  parameter int COEF_W = 32,
  parameter int N      = 701,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [COEF_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_data
);
  localparam int CW = $clog2(COEF_W);
  localparam logic [CW-1:0] CNT_TOP = CW'(COEF_W - 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
  typedef enum logic [2:0] {IDLE, READ, LOAD, SHIFT, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [COEF_W-1:0] sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] res_q, res_d;
  logic bit_in;
  // next-state: sequence the index walk and run the MSB-first residue machine (2r+b mod 3)
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    sh_d = sh_q;
    cnt_d = cnt_q;
    res_d = res_q;
    bit_in = sh_q[COEF_W-1];
    case (state_q)
      IDLE: if (start) begin
        state_d = READ;
        idx_d = '0;
      end
      READ: state_d = LOAD;
      LOAD: begin
        sh_d = rd_data;
        res_d = 2'd0;
        cnt_d = CNT_TOP;
        state_d = SHIFT;
      end
      SHIFT: begin
        sh_d = {sh_q[COEF_W-2:0], 1'b0};
        res_d = (res_q == 2'd0) ? {1'b0, bit_in} :
                (res_q == 2'd1) ? (bit_in ? 2'd0 : 2'd2) :
                                  (bit_in ? 2'd2 : 2'd1);
        cnt_d = cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? WRITE : SHIFT;
      end
      WRITE: if (idx_q == LAST) state_d = DONE;
      else begin
        idx_d = idx_q + 1'b1;
        state_d = READ;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers; async reset discards any partially reduced coefficient
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      sh_q <= '0;
      cnt_q <= '0;
      res_q <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
    end
  end
  assign busy = (state_q == READ) || (state_q == LOAD) || (state_q == SHIFT) || (state_q == WRITE);
  assign done = state_q == DONE;
  assign rd_en = state_q == READ;
  assign rd_addr = idx_q;
  assign wr_en = state_q == WRITE;
  assign wr_addr = idx_q;
  assign wr_data = res_q;
  res_legal: assert property (@(posedge clk) disable iff (!rst_n) res_q != 2'd3);
  idx_legal: assert property (@(posedge clk) disable iff (!rst_n) idx_q <= LAST);
endmodule

// File: tb/tb_poly_mod3_seq.sv
// tb_poly_mod3_seq: table-driven and randomized checks of poly_mod3_seq on three parameter sets
module tb_poly_mod3_seq;
  localparam int NONE = 1 << 20;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic a_start, a_busy, a_done, a_rd_en, a_wr_en;
  logic [2:0] a_rd_addr, a_wr_addr;
  logic [7:0] a_rd_data;
  logic [1:0] a_wr_data;
  logic b_start, b_busy, b_done, b_rd_en, b_wr_en;
  logic [1:0] b_rd_addr, b_wr_addr;
  logic [31:0] b_rd_data;
  logic [1:0] b_wr_data;
  logic c_start, c_busy, c_done, c_rd_en, c_wr_en;
  logic [0:0] c_rd_addr, c_wr_addr;
  logic [1:0] c_rd_data;
  logic [1:0] c_wr_data;
  poly_mod3_seq #(.COEF_W(8), .N(4), .ADDR_W(3)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data));
  poly_mod3_seq #(.COEF_W(32), .N(3), .ADDR_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data));
  poly_mod3_seq #(.COEF_W(2), .N(1), .ADDR_W(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .busy(c_busy), .done(c_done),
    .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data));
  logic [7:0] a_mem [8];
  logic [31:0] b_mem [4];
  logic [1:0] c_mem [2];
  always @(posedge clk) if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
  always @(posedge clk) if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
  always @(posedge clk) if (c_rd_en) c_rd_data <= c_mem[c_rd_addr];
  typedef struct {int d; bit w; int addr; int data;} ev_t;
  ev_t ev_q[$];
  always @(posedge clk) begin
    if (a_rd_en) ev_q.push_back('{0, 1'b0, int'(a_rd_addr), 0});
    if (a_wr_en) ev_q.push_back('{0, 1'b1, int'(a_wr_addr), int'(a_wr_data)});
    if (b_rd_en) ev_q.push_back('{1, 1'b0, int'(b_rd_addr), 0});
    if (b_wr_en) ev_q.push_back('{1, 1'b1, int'(b_wr_addr), int'(b_wr_data)});
    if (c_rd_en) ev_q.push_back('{2, 1'b0, int'(c_rd_addr), 0});
    if (c_wr_en) ev_q.push_back('{2, 1'b1, int'(c_wr_addr), int'(c_wr_data)});
  end
  typedef struct {logic [31:0] coef; int res;} vec_t;
  vec_t t_a [4];
  vec_t t_b [3];
  int checks = 0, errors = 0;
  int exp_r [8];
  task automatic chk(input string nm, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask
  function automatic logic [3:0] sig(input int d);
    return d == 0 ? {a_busy, a_done, a_rd_en, a_wr_en} :
           d == 1 ? {b_busy, b_done, b_rd_en, b_wr_en} : {c_busy, c_done, c_rd_en, c_wr_en};
  endfunction
  function automatic logic [21:0] outs(input int d);
    return d == 0 ? {sig(0), 8'(a_rd_addr), 8'(a_wr_addr), a_wr_data} :
           d == 1 ? {sig(1), 8'(b_rd_addr), 8'(b_wr_addr), b_wr_data} :
                    {sig(2), 8'(c_rd_addr), 8'(c_wr_addr), c_wr_data};
  endfunction
  function automatic logic [3:0] exp_sig(input int t, input int t0, input int per, input int n);
    int u = t - t0;
    logic bz = (u >= 0) && (u < per * n);
    return {bz, u == per * n, bz && (u % per == 0), bz && (u % per == per - 1)};
  endfunction
  task automatic set_start(input int d, input logic v);
    if (d == 0) a_start = v;
    else if (d == 1) b_start = v;
    else c_start = v;
  endtask
  task automatic launch(input int d);
    set_start(d, 1'b1);
    @(posedge clk);
    #1 set_start(d, 1'b0);
  endtask
  task automatic watch(input int d, input int len, input int per, input int n,
                       input int t0a, input int t0b, input string nm);
    for (int t = 1; t <= len; t++) begin
      @(negedge clk);
      chk($sformatf("%s busy/done/rd/wr t=%0d", nm, t), sig(d),
          exp_sig(t, t0a, per, n) | exp_sig(t, t0b, per, n));
    end
  endtask
  task automatic wait_done(input int d, input int bound, input string nm);
    bit seen = 1'b0;
    logic [3:0] s;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      s = sig(d);
      seen = s[2];
    end
    chk(nm, seen, 1);
  endtask
  task automatic chk_log(input int d, input int i0, input int nw, input int nr, input string nm);
    int kw = 0, kr = 0;
    for (int i = i0; i < ev_q.size(); i++) if (ev_q[i].d == d) begin
      if (ev_q[i].w) begin
        if (kw < 8) begin
          chk($sformatf("%s wr_addr #%0d", nm, kw), ev_q[i].addr, kw);
          chk($sformatf("%s wr_data #%0d", nm, kw), ev_q[i].data, exp_r[kw]);
        end
        kw++;
      end else begin
        chk($sformatf("%s rd_addr #%0d", nm, kr), ev_q[i].addr, kr);
        kr++;
      end
    end
    chk({nm, " write count"}, kw, nw);
    chk({nm, " read count"}, kr, nr);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    int i0;
    t_a[0] = '{32'd0, 0};
    t_a[1] = '{32'd1, 1};
    t_a[2] = '{32'd255, 0};
    t_a[3] = '{32'd128, 2};
    t_b[0] = '{32'hFFFF_FFFF, 0};
    t_b[1] = '{32'h8000_0000, 2};
    t_b[2] = '{32'd200, 2};
    rst_n = 1'b0;
    a_start = 1'b0;
    b_start = 1'b0;
    c_start = 1'b0;
    #3;
    for (int d = 0; d < 3; d++) chk($sformatf("reset outputs dut%0d", d), outs(d), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      a_mem[k] = t_a[k].coef[7:0];
      exp_r[k] = t_a[k].res;
    end
    i0 = ev_q.size();
    launch(0);
    watch(0, 46, 11, 4, 1, NONE, "a_run");
    chk_log(0, i0, 4, 4, "a_run");
    a_start = 1'b1;
    @(posedge clk);
    watch(0, 92, 11, 4, 1, 47, "a_hold");
    a_start = 1'b0;
    watch(0, 3, 11, 4, NONE, NONE, "a_hold_idle");
    i0 = ev_q.size();
    launch(0);
    for (int t = 1; t <= 28; t++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("a async reset outputs", outs(0), 0);
    @(negedge clk);
    chk("a held reset outputs", outs(0), 0);
    rst_n = 1'b1;
    watch(0, 4, 11, 4, NONE, NONE, "a_post_rst");
    chk_log(0, i0, 2, 3, "a_rst");
    i0 = ev_q.size();
    launch(0);
    watch(0, 46, 11, 4, 1, NONE, "a_rerun");
    chk_log(0, i0, 4, 4, "a_rerun");
    for (int k = 0; k < 3; k++) begin
      b_mem[k] = t_b[k].coef;
      exp_r[k] = t_b[k].res;
    end
    i0 = ev_q.size();
    launch(1);
    watch(1, 107, 35, 3, 1, NONE, "b_run");
    chk_log(1, i0, 3, 3, "b_run");
    c_mem[0] = 2'd3;
    exp_r[0] = 0;
    i0 = ev_q.size();
    launch(2);
    watch(2, 7, 5, 1, 1, NONE, "c_run");
    chk_log(2, i0, 1, 1, "c_run");
    for (int r = 0; r < 334; r++) begin
      for (int k = 0; k < 3; k++) begin
        b_mem[k] = $urandom;
        exp_r[k] = int'(b_mem[k] % 32'd3);
      end
      i0 = ev_q.size();
      launch(1);
      wait_done(1, 120, "rnd done");
      @(negedge clk);
      chk_log(1, i0, 3, 3, $sformatf("rnd%0d", r));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
